// File: rtl/alu.sv
// Registered 32-bit ALU with zero/negative/carry/overflow flags, one cycle latency.
// Optional rotate opcodes are enabled by defining ALU_ROTATE_EN.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  opcode,
  output logic [31:0] result,
  output logic        zero,
  output logic        negative,
  output logic        carry,
  output logic        overflow
);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_NOT   = 5'b00100;
  localparam logic [4:0] OP_SLL   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00111;
  localparam logic [4:0] OP_SRA   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_SLTU  = 5'b01010;
  localparam logic [4:0] OP_NOR   = 5'b01011;
  localparam logic [4:0] OP_PASSB = 5'b01100;
`ifdef ALU_ROTATE_EN
  localparam logic [4:0] OP_ROL   = 5'b01101;
  localparam logic [4:0] OP_ROR   = 5'b01110;
`endif

  logic [32:0] sum_s;
  logic [32:0] diff_s;
  logic [4:0]  shamt_s;
  logic [31:0] res_s;
  logic        carry_s;
  logic        ovf_s;
`ifdef ALU_ROTATE_EN
  logic [63:0] rol_s;
  logic [63:0] ror_s;
`endif

  // Result and flag computation for the current opcode
  always_comb begin
    // diff_s[32] is the borrow: set exactly when unsigned a < unsigned b
    sum_s   = {1'b0, a} + {1'b0, b};
    diff_s  = {1'b0, a} - {1'b0, b};
    shamt_s = b[4:0];
`ifdef ALU_ROTATE_EN
    rol_s   = {a, a} << shamt_s;
    ror_s   = {a, a} >> shamt_s;
`endif
    res_s   = 32'd0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_s   = sum_s[31:0];
        carry_s = sum_s[32];
        ovf_s   = (a[31] == b[31]) && (sum_s[31] != a[31]);
      end
      OP_SUB: begin
        res_s   = diff_s[31:0];
        carry_s = diff_s[32];
        ovf_s   = (a[31] != b[31]) && (diff_s[31] != a[31]);
      end
      OP_AND:   res_s = a & b;
      OP_OR:    res_s = a | b;
      OP_NOT:   res_s = ~a;
      OP_SLL:   res_s = a << shamt_s;
      OP_SRL:   res_s = a >> shamt_s;
      OP_XOR:   res_s = a ^ b;
      OP_SRA:   res_s = $unsigned($signed(a) >>> shamt_s);
      OP_SLT:   res_s = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU:  res_s = {31'd0, (a < b)};
      OP_NOR:   res_s = ~(a | b);
      OP_PASSB: res_s = b;
`ifdef ALU_ROTATE_EN
      OP_ROL:   res_s = rol_s[63:32];
      OP_ROR:   res_s = ror_s[31:0];
`endif
      default: begin
        res_s   = 32'd0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  // Output register; reset wins over any operation presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= 32'd0;
      zero     <= 1'b1;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      result   <= res_s;
      zero     <= (res_s == 32'd0);
      negative <= res_s[31];
      carry    <= carry_s;
      overflow <= ovf_s;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; expected values are hand-computed.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  opcode;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .result   (result),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] r, input logic z,
                           input logic n, input logic c, input logic v);
    check({tag, ".result"},   result,           r);
    check({tag, ".zero"},     {31'd0, zero},     {31'd0, z});
    check({tag, ".negative"}, {31'd0, negative}, {31'd0, n});
    check({tag, ".carry"},    {31'd0, carry},    {31'd0, c});
    check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, v});
  endtask

  task automatic op(input logic [31:0] aa, input logic [31:0] bb, input logic [4:0] oc);
    a = aa;
    b = bb;
    opcode = oc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a = 32'd10;
    b = 32'd20;
    opcode = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    rst = 1'b0;
    op(32'd10, 32'd20, 5'b00000);            check_all("add", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'd10, 32'd20, 5'b00001);            check_all("sub", 32'hFFFFFFF6, 1'b0, 1'b1, 1'b1, 1'b0);
    op(32'd10, 32'd20, 5'b00010);            check_all("and", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(32'd10, 32'd20, 5'b00011);            check_all("or", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'd10, 32'd20, 5'b00111);            check_all("xor", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'd10, 32'd20, 5'b00100);            check_all("not", 32'hFFFFFFF5, 1'b0, 1'b1, 1'b0, 1'b0);
    op(32'd10, 32'd20, 5'b01011);            check_all("nor", 32'hFFFFFFE1, 1'b0, 1'b1, 1'b0, 1'b0);

    op(32'd10, 32'd2, 5'b00101);             check_all("sll", 32'd40, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'd10, 32'd2, 5'b00110);             check_all("srl", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'h80000000, 32'd4, 5'b01000);       check_all("sra", 32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0);
    op(32'h80000000, 32'd4, 5'b00110);       check_all("srl_msb", 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'hDEADBEEF, 32'd0, 5'b00101);       check_all("sll_zero", 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    op(32'hDEADBEEF, 32'd32, 5'b01000);      check_all("sra_amt32", 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
    op(32'h12345678, 32'd33, 5'b00110);      check_all("srl_amt33", 32'h091A2B3C, 1'b0, 1'b0, 1'b0, 1'b0);

    op(32'h7FFFFFFF, 32'd1, 5'b00000);       check_all("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    op(32'h80000000, 32'hFFFFFFFF, 5'b00001); check_all("sub_noovf", 32'h80000001, 1'b0, 1'b1, 1'b1, 1'b0);
    op(32'h80000000, 32'd1, 5'b00001);       check_all("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    op(32'hFFFFFFFF, 32'd1, 5'b00000);       check_all("add_carry", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    op(32'h80000000, 32'h80000000, 5'b00000); check_all("add_cv", 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    op(32'd20, 32'd10, 5'b00001);            check_all("sub_pos", 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);

    op(32'hFFFFFFFF, 32'd1, 5'b01001);       check_all("slt", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'hFFFFFFFF, 32'd1, 5'b01010);       check_all("sltu", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(32'd1, 32'hFFFFFFFF, 5'b01010);       check_all("sltu_true", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'd5, 32'h12345678, 5'b01100);       check_all("passb", 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'd5, 32'd3, 5'b11111);              check_all("undef", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef ALU_ROTATE_EN
    op(32'h80000001, 32'd1, 5'b01101);       check_all("rol", 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
    op(32'h80000001, 32'd1, 5'b01110);       check_all("ror", 32'hC0000000, 1'b0, 1'b1, 1'b0, 1'b0);
    op(32'h80000001, 32'd0, 5'b01101);       check_all("rol_zero", 32'h80000001, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    op(32'h80000001, 32'd1, 5'b01101);       check_all("rol_off", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(32'h80000001, 32'd1, 5'b01110);       check_all("ror_off", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Flags must not stick: a carry/overflow result followed by a plain result
    op(32'h7FFFFFFF, 32'd1, 5'b00000);
    op(32'd3, 32'd4, 5'b00000);              check_all("nosticky", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset takes priority over a live operation in the same cycle
    rst = 1'b1;
    op(32'hFFFFFFFF, 32'd1, 5'b00001);       check_all("rst_prio", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    op(32'hFFFFFFFF, 32'd1, 5'b00001);       check_all("post_rst", 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
